lc3x_muldiv_seq: RTL and testbench
==================================

Name: lc3x_muldiv_seq

Overview:
- Multi-cycle sequencer for the LC-3X MULT and DIV extensions. The control word marks both as single-cycle EX ops, but they need an iterative unit.
- Sits beside the ALU in EX. Accepts an op, runs 16 shift/add or shift/subtract iterations, and applies the sign. Holds the pipeline stalled until the result is ready, then pulses done.
- Feeds the alu_result_mux inputs already reserved for mult (2'b10) and div (2'b11).

Parameters:
- WIDTH, 16, operand/result width in bits.
- ITERS, 16, iteration count; must equal WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  EX holds a valid mult or div op; level, held by the pipeline while stalled.
- mult_op  in  1  from control word.
- div_op  in  1  from control word.
- flush  in  1  EX instruction squashed (branch/trap redirect).
- a  in  WIDTH  SR1 value (dividend/multiplicand), after forwarding.
- b  in  WIDTH  SR2 value (divisor/multiplier), after forwarding.
- stall  out  1  freeze IF/ID/EX; combinational.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  WIDTH  signed product low half or signed quotient.
- div_by_zero  out  1  qualifies done for a DIV with b==0.

Behaviour:
- Reset (async): state=IDLE, counter=0, result=0, done=0, div_by_zero=0. Internal accumulators are cleared.
- Start condition: req & (mult_op ^ div_op) & ~flush in IDLE. Neither op or both ops set: no start, stall=0, state stays IDLE.
- States:
  - IDLE: on start, latch sa=a[15], sb=b[15], |a|, |b| and the op. Clear the 32-bit accumulator. Counter=0. Go to BUSY.
  - BUSY, MULT: per cycle, if multiplier LSB then acc_hi += |a|; then shift acc right 1.
  - BUSY, DIV: restoring step — shift remainder:quotient left 1; if rem >= |b| then rem -= |b| and q[0]=1.
  - BUSY exit: counter increments each cycle; counter==ITERS-1 goes to SIGN.
  - SIGN: negate the result if sa^sb. MULT takes the low WIDTH bits of the signed 32-bit product. DIV truncates toward zero. Go to DONE.
  - DONE: done=1 for exactly one cycle; result registered. Return to IDLE.
- Latency: req first high in cycle 0 → done high in cycle 18. A new op may start in the cycle after DONE, giving back-to-back ops.
- stall = req & (mult_op ^ div_op) & ~done & ~flush.
- result holds its last value until the next DONE. It is never changed outside DONE, except by reset.
- Divide by zero: skip BUSY; IDLE→SIGN→DONE with result=16'h0000 and div_by_zero=1 (done in cycle 2).
- DIV overflow: -32768 / -1 = 16'h8000 (wraps); div_by_zero=0.
- MULT overflow: silently truncated to the low 16 bits.
- Flush in any non-IDLE state: go to IDLE next edge; no done; result unchanged. Flush in DONE: done still pulses, and the pipeline ignores it.
- Reset mid-operation: immediate IDLE; all outputs return to reset values.
- Operand changes on a/b after the start cycle are ignored.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in BUSY for MULT, go to SIGN as soon as the remaining multiplier bits are all zero. Latency becomes 3 + (index of the highest set bit of |b|) cycles. |b|==0 goes IDLE→SIGN directly (done in cycle 2, result 0). DIV is unaffected.
- Undefined: fixed 18-cycle latency for all non-zero-divisor ops.

Decomposition:
- Add to lc3b_types: muldiv_state_t enum {IDLE, BUSY, SIGN, DONE}, and MULDIV_ITERS=16.
- Use the existing lc3b_word for a, b and result.
- One sub-module: muldiv_abs, a combinational two's-complement magnitude/conditional-negate (WIDTH-parameterised). It is instanced for operand magnitude and for sign fix.

Test Plan:
- MULT a=7, b=16'hFFFD (-3), req held → stall high in cycles 0–17; done in cycle 18 with result=16'hFFEB; stall low in cycle 18.
- MULT a=300, b=300 → result=16'h5F90 (truncated 90000), done in cycle 18.
- DIV a=16'hFFF9 (-7), b=2 → result=16'hFFFD (-3), div_by_zero=0. Then back-to-back DIV a=16'h8000, b=16'hFFFF → result=16'h8000.
- DIV a=5, b=0 → done in cycle 2, result=0, div_by_zero=1.
- MULT a=9, b=4 with flush pulsed in cycle 5 → no done, state IDLE in cycle 6, result unchanged. Then a new MULT 9×4 → 16'h0024.
- Reset asserted asynchronously mid-BUSY (cycle 8) → done=0, result=0, stall=0 immediately. With MULDIV_EARLY_OUT_EN, MULT a=5, b=1 → done in cycle 3, result=5.

Source files
------------

// File: rtl/lc3x_muldiv_seq_pkg.sv
// rtl/lc3x_muldiv_seq_pkg.sv - shared types and constants for the LC-3X mult/div sequencer
package lc3x_muldiv_seq_pkg;

  localparam int MULDIV_ITERS = 16;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_abs.sv
// rtl/muldiv_abs.sv - combinational two's-complement conditional negate (magnitude or sign fix)
module muldiv_abs #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  // Negating the most negative value wraps to itself, which is the correct
  // unsigned magnitude, so no special case is needed.
  assign out = neg ? -val : val;

endmodule

// File: rtl/lc3x_muldiv_seq.sv
// rtl/lc3x_muldiv_seq.sv - iterative MULT/DIV sequencer beside the EX ALU (optional MULDIV_EARLY_OUT_EN)
module lc3x_muldiv_seq
  import lc3x_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITERS = MULDIV_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             mult_op,
  input  logic             div_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CW = $clog2(ITERS);

  muldiv_state_t    state, state_nx;
  logic [CW-1:0]    cnt;
  logic             op_div;
  logic             neg;
  // opa: multiplicand shifting left (MULT) or dividend/quotient shifting left (DIV)
  // opb: multiplier shifting right (MULT) or divisor (DIV)
  // acc: running low product (MULT) or partial remainder (DIV)
  logic [WIDTH-1:0] opa, opb, acc;
  logic [WIDTH-1:0] mag_a, mag_b, fixed;
  logic             start, load_res, zero_skip, mult_early;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nx;

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (.val(a), .neg(a[WIDTH-1]), .out(mag_a));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (.val(b), .neg(b[WIDTH-1]), .out(mag_b));
  muldiv_abs #(.WIDTH(WIDTH)) u_sign  (.val(op_div ? opa : acc), .neg(neg), .out(fixed));

  assign start = (state == IDLE) & req & (mult_op ^ div_op) & ~flush;
  assign done  = (state == DONE);
  assign stall = req & (mult_op ^ div_op) & ~done & ~flush;

  // Restoring division step: shift remainder:quotient left, subtract if it fits.
  assign rem_sh = {acc, opa[WIDTH-1]};
  assign div_ge = (rem_sh >= {1'b0, opb});
  assign rem_nx = div_ge ? (rem_sh[WIDTH-1:0] - opb) : rem_sh[WIDTH-1:0];

`ifdef MULDIV_EARLY_OUT_EN
  // Zero multiplier or zero divisor has nothing to iterate over.
  assign zero_skip  = (mag_b == '0);
  // The current multiplier bit is the last set one: no further adds can occur.
  assign mult_early = ~op_div & (opb[WIDTH-1:1] == '0);
`else
  assign zero_skip  = div_op & (mag_b == '0);
  assign mult_early = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode; the result register loads on the SIGN to DONE edge.
  always_comb begin
    state_nx = state;
    load_res = 1'b0;
    case (state)
      IDLE: if (start) state_nx = zero_skip ? SIGN : BUSY;
      BUSY: begin
        if (flush)                                   state_nx = IDLE;
        else if (cnt == CW'(ITERS - 1) || mult_early) state_nx = SIGN;
      end
      SIGN: begin
        if (flush) state_nx = IDLE;
        else begin
          state_nx = DONE;
          load_res = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch at start and one shift/add or shift/subtract per BUSY cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op_div <= 1'b0;
      neg    <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
    end else if (start) begin
      cnt    <= '0;
      op_div <= div_op;
      neg    <= a[WIDTH-1] ^ b[WIDTH-1];
      opa    <= mag_a;
      opb    <= mag_b;
      acc    <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
      if (op_div) begin
        acc <= rem_nx;
        opa <= {opa[WIDTH-2:0], div_ge};
      end else begin
        if (opb[0]) acc <= acc + opa;
        opa <= opa << 1;
        opb <= opb >> 1;
      end
    end
  end

  // Architectural result; changes only when entering DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (load_res) begin
      result      <= (op_div && opb == '0) ? '0 : fixed;
      div_by_zero <= op_div && (opb == '0);
    end
  end

endmodule

// File: tb/tb_lc3x_muldiv_seq.sv
// tb/tb_lc3x_muldiv_seq.sv - scoreboard bench for the LC-3X mult/div sequencer
module tb_lc3x_muldiv_seq;
  import lc3x_muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req, mult_op, div_op, flush;
  logic [15:0] a, b, result;
  logic        stall, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  lc3x_muldiv_seq dut (
    .clk(clk), .reset(reset), .req(req), .mult_op(mult_op), .div_op(div_op),
    .flush(flush), .a(a), .b(b), .stall(stall), .done(done),
    .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic d, input logic [15:0] bv);
`ifdef MULDIV_EARLY_OUT_EN
    logic [15:0] mag;
    int          msb;
`endif
    if (d) return (bv == 16'h0) ? 2 : 18;
`ifdef MULDIV_EARLY_OUT_EN
    mag = bv[15] ? -bv : bv;
    if (mag == 16'h0) return 2;
    msb = 0;
    for (int i = 0; i < 16; i++) if (mag[i]) msb = i;
    return 3 + msb;
`else
    return 18;
`endif
  endfunction

  // Entered and left at the start of a cycle (posedge + 1).
  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] res, input logic dz);
    exp_t e;
    int   cyc;
    bit   got;
    e.res = res; e.dbz = dz; e.lat = exp_lat(d, bv);
    sb.push_back(e);
    req = 1'b1; mult_op = m; div_op = d; a = av; b = bv;
    cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      if (cyc == 1) begin a = 16'($urandom); b = 16'($urandom); end
      @(negedge clk);
      if (done) begin
        got = 1;
        e = sb.pop_front();
        chk($sformatf("%s_lat", tag), 32'(cyc), 32'(e.lat));
        chk($sformatf("%s_res", tag), 32'(result), 32'(e.res));
        chk($sformatf("%s_dbz", tag), 32'(div_by_zero), 32'(e.dbz));
        chk($sformatf("%s_stall_done", tag), 32'(stall), 32'd0);
      end else begin
        chk($sformatf("%s_stall_c%0d", tag, cyc), 32'(stall), 32'd1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!got) begin
      chk($sformatf("%s_timeout", tag), 32'(got), 32'd1);
      void'(sb.pop_front());
    end
    req = 1'b0; mult_op = 1'b0; div_op = 1'b0;
  endtask

  task automatic run_flush(input logic [15:0] av, input logic [15:0] bv,
                           input int fc, input logic [15:0] prev);
    req = 1'b1; mult_op = 1'b1; div_op = 1'b0; a = av; b = bv;
    for (int c = 0; c <= fc; c++) begin
      flush = (c == fc);
      @(negedge clk);
      chk($sformatf("flush_nodone_c%0d", c), 32'(done), 32'd0);
      if (c == fc) chk("flush_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
    end
    flush = 1'b0; req = 1'b0; mult_op = 1'b0;
    @(negedge clk);
    chk("flush_state_idle", 32'(dut.state), 32'(IDLE));
    chk("flush_done_low", 32'(done), 32'd0);
    chk("flush_result_held", 32'(result), 32'(prev));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; mult_op = 1'b0; div_op = 1'b0; flush = 1'b0;
    a = 16'h0; b = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Both op bits set, then neither: never starts, never stalls.
    req = 1'b1; mult_op = 1'b1; div_op = 1'b1; a = 16'd3; b = 16'd4;
    #1 chk("both_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mult_op = 1'b0; div_op = 1'b0;
    #1 chk("none_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("both_state_idle", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #1;
    @(negedge clk);
    chk("none_state_idle", 32'(dut.state), 32'(IDLE));
    chk("none_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    req = 1'b0;

    run_op("div_by_zero", 1'b0, 1'b1, 16'd5,    16'h0000, 16'h0000, 1'b1);
    run_op("div_m7_2",    1'b0, 1'b1, 16'hFFF9, 16'd2,    16'hFFFD, 1'b0);
    run_op("div_ovf",     1'b0, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b0);
    run_op("div_100_7",   1'b0, 1'b1, 16'd100,  16'd7,    16'h000E, 1'b0);
    run_op("div_7_m7",    1'b0, 1'b1, 16'd7,    16'hFFF9, 16'hFFFF, 1'b0);
    run_op("mul_7_m3",    1'b1, 1'b0, 16'd7,    16'hFFFD, 16'hFFEB, 1'b0);
    run_op("mul_300_300", 1'b1, 1'b0, 16'd300,  16'd300,  16'h5F90, 1'b0);
    run_op("mul_min_m1",  1'b1, 1'b0, 16'h8000, 16'hFFFF, 16'h8000, 1'b0);
    run_op("mul_x_0",     1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b0);
    run_op("div_5_3",     1'b0, 1'b1, 16'd5,    16'd3,    16'h0001, 1'b0);

`ifdef MULDIV_EARLY_OUT_EN
    run_flush(16'd9, 16'd4, 2, 16'h0001);
`else
    run_flush(16'd9, 16'd4, 5, 16'h0001);
`endif
    run_op("mul_9_4", 1'b1, 1'b0, 16'd9, 16'd4, 16'h0024, 1'b0);

    // Asynchronous reset in the middle of BUSY.
    req = 1'b1; mult_op = 1'b1; div_op = 1'b0; a = 16'd5; b = 16'h7FFF;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pre_rst_busy", 32'(dut.state), 32'(BUSY));
    #2;
    reset = 1'b1; req = 1'b0; mult_op = 1'b0;
    #1;
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul_5_1", 1'b1, 1'b0, 16'd5, 16'd1, 16'h0005, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
